// File: rtl/io_intr_controller.sv
// io_intr_controller: prioritized interrupt controller on the IO bus.
// Latches source edges into PEND, applies MASK, and raises intr for the
// lowest-index unmasked pending source. On intr_ack it latches that source's
// vector and keeps it in service until software writes EOI.
module io_intr_controller #(
  parameter int          NUM_SRC  = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_03C0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               io_cs,
  input  logic               io_wr,
  input  logic               io_rd,
  input  logic [11:0]        Address,
  input  logic [31:0]        D_In,
  output logic [31:0]        D_Out,
  output logic               intr,
  input  logic               intr_ack,
  output logic               in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_VEC  = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [31:0]        vec_q, vec_d;

  logic [1:0]         reg_sel;
  logic               wr_en;
  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] cands;
  logic [NUM_SRC-1:0] cand_onehot;
  logic               any_cand;
  logic [2:0]         cand_id;
  logic               ack_take;
  logic               eoi_wr;
  logic [NUM_SRC-1:0] w1c_bits;
  logic [NUM_SRC-1:0] ack_bits;

  // Upper data bits and the byte/unused address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{D_In[31:NUM_SRC], Address[11:4], Address[1:0]};

  assign reg_sel     = Address[3:2];
  assign wr_en       = io_cs & io_wr;
  assign src_rise    = src_irq & ~src_prev_q;
  assign cands       = pend_q & ~mask_q;
  assign any_cand    = |cands;
  // Isolate the lowest set bit: that is the highest-priority candidate.
  assign cand_onehot = cands & (~cands + NUM_SRC'(1));
  assign ack_take    = (state_q == REQ) & intr_ack & any_cand;
  assign eoi_wr      = wr_en & (reg_sel == REG_EOI);
  assign w1c_bits    = (wr_en && reg_sel == REG_PEND) ? D_In[NUM_SRC-1:0] : '0;
  assign ack_bits    = ack_take ? cand_onehot : '0;

  // Encode the lowest-index candidate as a small id (0 when none).
  always_comb begin
    cand_id = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cands[i]) cand_id = 3'(i);
    end
  end

  // Pending and mask next state; a new edge beats a same-cycle clear.
  always_comb begin
    pend_d = (pend_q & ~w1c_bits & ~ack_bits) | src_rise;
    mask_d = (wr_en && reg_sel == REG_MASK) ? D_In[NUM_SRC-1:0] : mask_q;
  end

  // Request/service FSM next state and vector capture on acknowledge.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        if (any_cand) state_d = REQ;
      end
      REQ: begin
        if (ack_take) begin
          state_d = SERVICE;
          vec_d   = VEC_BASE + {27'd0, cand_id, 2'b00};
        end else if (!any_cand) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      mask_q     <= '1;
      src_prev_q <= '0;
      vec_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      src_prev_q <= src_irq;
      vec_q      <= vec_d;
    end
  end

  // CPU handshake outputs decoded straight from the state register.
  assign intr       = (state_q == REQ);
  assign in_service = (state_q == SERVICE);

  // Read mux; drives zero when not selected so the bus can be OR-muxed.
  always_comb begin
    D_Out = 32'h0;
    if (io_cs && io_rd) begin
      unique case (reg_sel)
        REG_PEND: D_Out[NUM_SRC-1:0] = pend_q;
        REG_MASK: D_Out[NUM_SRC-1:0] = mask_q;
        REG_VEC:  D_Out = in_service ? vec_q : {any_cand, 23'd0, 5'd0, cand_id};
        default:  D_Out = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_intr_controller.sv
// Directed, table-driven bench for io_intr_controller (NUM_SRC = 4).
// Each row drives one cycle of inputs and checks outputs before the next edge.
module tb_io_intr_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_irq;
  logic        io_cs, io_wr, io_rd;
  logic [11:0] Address;
  logic [31:0] D_In;
  logic [31:0] D_Out;
  logic        intr;
  logic        intr_ack;
  logic        in_service;

  int total = 0;
  int bad   = 0;

  io_intr_controller #(.NUM_SRC(4), .VEC_BASE(32'h0000_03C0)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .io_cs      (io_cs),
    .io_wr      (io_wr),
    .io_rd      (io_rd),
    .Address    (Address),
    .D_In       (D_In),
    .D_Out      (D_Out),
    .intr       (intr),
    .intr_ack   (intr_ack),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  src;
    logic        wr;
    logic        rd;
    logic [11:0] addr;
    logic [31:0] din;
    logic        ack;
    logic        e_intr;
    logic        e_isv;
    logic [31:0] e_dout;
  } row_t;

  row_t tbl[$];

  localparam logic [11:0] A_PEND = 12'h000;
  localparam logic [11:0] A_MASK = 12'h004;
  localparam logic [11:0] A_VEC  = 12'h008;
  localparam logic [11:0] A_EOI  = 12'h00C;

  function automatic row_t mk(input logic [3:0] src, input logic wr, input logic rd,
                              input logic [11:0] addr, input logic [31:0] din,
                              input logic ack, input logic e_intr, input logic e_isv,
                              input logic [31:0] e_dout);
    row_t r;
    r.src = src; r.wr = wr; r.rd = rd; r.addr = addr; r.din = din; r.ack = ack;
    r.e_intr = e_intr; r.e_isv = e_isv; r.e_dout = e_dout;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_row(input int idx, input row_t r);
    @(posedge clk);
    #1;
    src_irq  = r.src;
    io_cs    = r.wr | r.rd;
    io_wr    = r.wr;
    io_rd    = r.rd;
    Address  = r.addr;
    D_In     = r.din;
    intr_ack = r.ack;
    @(negedge clk);
    chk($sformatf("row%0d intr", idx), {31'd0, intr}, {31'd0, r.e_intr});
    chk($sformatf("row%0d in_service", idx), {31'd0, in_service}, {31'd0, r.e_isv});
    chk($sformatf("row%0d D_Out", idx), D_Out, r.e_dout);
  endtask

  initial begin
    int cyc;
    //              src  wr rd addr    din  ack intr isv dout
    // reset state and first interrupt on source 2
    tbl.push_back(mk(4'h0, 0, 1, A_MASK, 0, 0, 0, 0, 32'h0000_000F));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 1, 0, A_MASK, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h4, 0, 1, A_MASK, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h4, 0, 1, A_PEND, 0, 0, 0, 0, 32'h4));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 1, 0, 32'h8000_0002));
    tbl.push_back(mk(4'h0, 0, 0, A_PEND, 0, 1, 1, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 0, 1, 32'h0000_03C8));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(4'h0, 1, 0, A_EOI,  0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 0, 0, 32'h0));
    // sources 3 and 1 together; priority, ignored ack in service, re-request after EOI
    tbl.push_back(mk(4'hA, 0, 1, A_PEND, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 0, 0, 32'hA));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 1, 0, 32'h8000_0001));
    tbl.push_back(mk(4'h0, 0, 0, A_PEND, 0, 1, 1, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 0, 1, 32'h0000_03C4));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 1, 0, 1, 32'h8));
    tbl.push_back(mk(4'h0, 1, 0, A_EOI,  0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 0, 0, 32'h8000_0003));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 1, 0, 32'h8000_0003));
    tbl.push_back(mk(4'h0, 0, 0, A_PEND, 0, 1, 1, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 0, 1, 32'h0000_03CC));
    tbl.push_back(mk(4'h0, 1, 0, A_EOI,  0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 0, 0, 32'h0));
    // masked source 0, unmask, EOI in REQ ignored, mask withdraws request
    tbl.push_back(mk(4'h0, 1, 0, A_MASK, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h1, 0, 1, A_MASK, 0, 0, 0, 0, 32'h1));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 0, 0, 32'h1));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 1, 0, A_MASK, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_MASK, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 1, 0, 32'h8000_0000));
    tbl.push_back(mk(4'h0, 1, 0, A_EOI,  0, 0, 1, 0, 32'h0));
    tbl.push_back(mk(4'h0, 1, 0, A_MASK, 1, 0, 1, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 1, 0, 32'h1));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 0, 0, 32'h1));
    tbl.push_back(mk(4'h0, 1, 0, A_PEND, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 1, 0, A_MASK, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 0, 0, 32'h0));
    // W1C of the only candidate while in REQ withdraws the request
    tbl.push_back(mk(4'h4, 0, 0, A_PEND, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 0, A_PEND, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 1, 0, A_PEND, 4, 0, 1, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 0, 0, 32'h0));
    // source 1 re-edges while in service; set beats same-cycle W1C
    tbl.push_back(mk(4'h2, 0, 0, A_PEND, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 0, A_PEND, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 0, A_PEND, 0, 1, 1, 0, 32'h0));
    tbl.push_back(mk(4'h2, 0, 1, A_VEC,  0, 0, 0, 1, 32'h0000_03C4));
    tbl.push_back(mk(4'h2, 0, 1, A_PEND, 0, 0, 0, 1, 32'h2));
    tbl.push_back(mk(4'h0, 0, 0, A_PEND, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(4'h2, 1, 0, A_PEND, 2, 0, 0, 1, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_PEND, 0, 0, 0, 1, 32'h2));
    tbl.push_back(mk(4'h0, 1, 0, A_EOI,  0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(4'h0, 0, 0, A_PEND, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 1, 0, 32'h8000_0001));
    tbl.push_back(mk(4'h0, 0, 0, A_PEND, 0, 1, 1, 0, 32'h0));
    tbl.push_back(mk(4'h0, 0, 1, A_VEC,  0, 0, 0, 1, 32'h0000_03C4));

    rst = 1'b1; src_irq = '0; io_cs = 0; io_wr = 0; io_rd = 0;
    Address = '0; D_In = '0; intr_ack = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_row(i, tbl[i]);

    // Asynchronous reset in mid-service: outputs clear before any clock edge.
    #1;
    rst = 1'b1; io_cs = 1; io_rd = 1; io_wr = 0; Address = A_MASK; intr_ack = 0;
    #1;
    chk("rst intr", {31'd0, intr}, 32'd0);
    chk("rst in_service", {31'd0, in_service}, 32'd0);
    chk("rst MASK", D_Out, 32'h0000_000F);
    Address = A_PEND;
    #1 chk("rst PEND", D_Out, 32'h0);
    Address = A_VEC;
    #1 chk("rst VECTOR", D_Out, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_service", {31'd0, in_service}, 32'd0);

    // Edge-to-intr latency on source 3, bounded wait.
    run_row(900, mk(4'h0, 1, 0, A_MASK, 0, 0, 0, 0, 32'h0));
    @(posedge clk);
    #1 io_cs = 0; io_wr = 0; io_rd = 0; src_irq = 4'h8;
    cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1 src_irq = 4'h0;
      if (intr) begin
        cyc = c;
        break;
      end
    end
    chk("edge-to-intr latency", cyc, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_intr_controller.md
# io_intr_controller

Prioritized interrupt controller between up to NUM_SRC IO interrupt sources and the CPU's single `intr`/`intr_ack` handshake. It sits on the IO memory bus beside the IO memory and is selected by the EXMEM-stage IO control bits. It latches source edges into a pending register and applies a software-writable mask. It presents the highest-priority request to the CPU, returns a vector on acknowledge, and holds the source in service until software writes end-of-interrupt (EOI).

## Interface
- `NUM_SRC`, 4 — number of interrupt sources (1..8).
- `VEC_BASE`, 32'h0000_03C0 — vector for source 0; source i vector = `VEC_BASE + (i << 2)`.
- `clk`  input  1  — system clock; all state changes on rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `src_irq`  input  NUM_SRC  — level inputs from sources; a rising edge requests an interrupt. Bit 0 has highest priority.
- `io_cs`  input  1  — controller select (EXMEM IO chip select, externally decoded).
- `io_wr`  input  1  — register write strobe.
- `io_rd`  input  1  — register read strobe.
- `Address`  input  12  — byte address; `Address[3:2]` selects the register.
- `D_In`  input  32  — write data.
- `D_Out`  output  32  — read data.
- `intr`  output  1  — interrupt request to the CPU.
- `intr_ack`  input  1  — CPU acknowledge.
- `in_service`  output  1  — high while a source is between acknowledge and EOI.

## Operation
- Register map, selected by `Address[3:2]`:
  - 0 PEND: read pending bits. Write-1-to-clear.
  - 1 MASK: read/write. A 1 blocks that source. Reset value is all ones.
  - 2 VECTOR: read only. `{valid, 23'b0, 8-bit id}` when idle; the latched vector value while in service.
  - 3 EOI: write any data to end the current service.
- Only bits [NUM_SRC-1:0] of PEND and MASK are implemented; unused bits read 0.
- Edge detect: `src_d` register. A pending bit sets when `src_irq[i] & ~src_d[i]`.
- Candidate: the lowest index in `PEND & ~MASK`.
- FSM states:
  - IDLE: if any candidate exists, go to REQ.
  - REQ: `intr` = 1.
    - If `intr_ack`: latch the candidate id and vector, clear that pending bit, go to SERVICE.
    - If the candidate set empties because of a mask or clear: go back to IDLE (request withdrawn).
  - SERVICE: `intr` = 0 and `in_service` = 1. An EOI write goes to IDLE.
  - No nesting: new requests stay pending during SERVICE.
- Writes take effect when `io_cs & io_wr`. `D_Out` = the selected register when `io_cs & io_rd`, else 32'h0, because the bus is externally muxed with the IO memory output.
- Simultaneous events and boundaries:
  - A set edge and a W1C on the same bit in the same cycle: set wins.
  - An edge on the source currently in service sets pending again; it is serviced after EOI.
  - The candidate in REQ is re-evaluated every cycle. The id latched is the candidate in the `intr_ack` cycle.
  - `intr_ack` in IDLE or SERVICE is ignored.
  - EOI in IDLE or REQ is ignored.
- Reset, including mid-service: PEND = 0, MASK = all ones, `src_d` = 0, state = IDLE, `intr` = 0, `in_service` = 0, VECTOR = 0. `D_Out` is combinational.

## Timing
- A rising edge on `src_irq` is seen at clock N. PEND is set after edge N. The FSM is in REQ after edge N+1, so `intr` is high after edge N+1. That is 2 cycles of latency from the edge to `intr`.
- `intr` is registered, i.e. decoded from the FSM state register, and is glitch-free.
- `intr_ack` high at edge M puts the FSM in SERVICE after M: `intr` low and `in_service` high. VECTOR and PEND update at the same edge.
- An EOI write at edge K gives IDLE after K. If another candidate exists, `intr` rises again after K+1.
- Register writes are visible to reads in the next cycle. Reads are combinational in the same cycle.

## Test plan
- Reset, then a pulse on `src_irq[2]` with MASK=0 → `intr`=1 two cycles after the edge. Assert `intr_ack` for 1 cycle → `intr`=0, `in_service`=1, VECTOR=32'h3C8, PEND=0.
- Edges on sources 3 and 1 in the same cycle, MASK=0 → the first ack gives VECTOR=32'h3C4. After EOI, `intr` re-asserts and the second ack gives 32'h3CC.
- Source 0 pending while MASK=4'b0001 → `intr` stays 0. Write MASK=0 → `intr`=1 two cycles later.
- In REQ, write PEND=4'b0100 (W1C) to clear the only candidate, source 2 → the FSM returns to IDLE and `intr` falls the next cycle.
- In SERVICE with source 1, a new edge on source 1 → PEND=4'b0010 and `intr` stays 0 until EOI, then re-asserts. A W1C and an edge on the same bit in the same cycle → the bit stays 1.
- Assert `rst` for 1 cycle during SERVICE → `intr`=0, `in_service`=0, PEND=0, MASK=4'b1111, VECTOR=0 immediately, without waiting for a clock edge.
